uart_adc_poller: RTL

Parametrised successor to the fixed four-channel UART ADC reader: polls an external serial ADC front-end over a UART link, one channel per poll slot, and publishes per-channel samples with valid flags and strobes. It adds configurable channel count, sample width, poll rate and command base, plus a response timeout with error counting. It sits between the board serial pins and the plugin register map.

---
 rtl/uart_adc_poller_pkg.sv | 35 +++
 rtl/uart_adc_poller_uart.sv | 115 +++++++++++
 rtl/uart_adc_poller.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/uart_adc_poller_pkg.sv
// uart_adc_poller_pkg
//   Shared definitions for the UART ADC poller: the poll FSM state type,
//   the command-byte helper and the derivations of the slot period and
//   response timeout (in clock cycles) from the top-level parameters.
package uart_adc_poller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_TX,
        ST_RECV,
        ST_COMMIT
    } state_t;

    // Clock cycles per poll slot.
    function automatic int slot_cycles(input int clk_freq, input int poll_hz);
        return clk_freq / poll_hz;
    endfunction

    // Response timeout in clock cycles: TIMEOUT_BYTES 10-bit frames.
    // Computed in 64 bits so fast clocks with long timeouts do not overflow.
    function automatic int timeout_cycles(input int clk_freq, input int baud,
                                          input int bytes);
        longint t;
        t = longint'(bytes) * longint'(10) * longint'(clk_freq) / longint'(baud);
        return int'(t);
    endfunction

    // Command byte for a channel; wraps modulo 256.
    function automatic logic [7:0] cmd_for(input logic [7:0] base,
                                           input logic [7:0] ch);
        return base + ch;
    endfunction

endpackage

// File: rtl/uart_adc_poller_uart.sv
// uart_tx / uart_rx
//   8N1 UART primitives used by the ADC poller.
//   uart_tx: clk, rst_n, start (1-cycle request, ignored while busy),
//            data[7:0], tx (idle high), busy (high from the cycle after
//            start until the stop bit has been fully sent).
//   uart_rx: clk, rst_n, rx (asynchronous line, idle high), data[7:0],
//            ready (1-cycle pulse at the middle of a valid stop bit).
module uart_tx #(
    parameter int CLKS_PER_BIT = 48
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);

    logic [CW-1:0] clk_cnt;
    logic [3:0]    bit_idx;
    logic [8:0]    shreg;   // {stop, data[7:0]}; start bit driven directly

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx      <= 1'b1;
            busy    <= 1'b0;
            clk_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '1;
        end else if (!busy) begin
            if (start) begin
                tx      <= 1'b0;
                busy    <= 1'b1;
                shreg   <= {1'b1, data};
                clk_cnt <= '0;
                bit_idx <= '0;
            end
        end else if (clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
            clk_cnt <= '0;
            if (bit_idx == 4'd9) begin
                busy <= 1'b0;
                tx   <= 1'b1;
            end else begin
                tx      <= shreg[0];
                shreg   <= {1'b1, shreg[8:1]};
                bit_idx <= bit_idx + 4'd1;
            end
        end else begin
            clk_cnt <= clk_cnt + CW'(1);
        end
    end
endmodule

module uart_rx #(
    parameter int CLKS_PER_BIT = 48
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       ready
);
    localparam int CW   = $clog2(CLKS_PER_BIT + 1);
    localparam int HALF = CLKS_PER_BIT / 2;

    logic          rx_meta, rx_s;
    logic          active;
    logic [CW-1:0] clk_cnt;
    logic [3:0]    bit_idx;   // 0 start, 1..8 data, 9 stop
    logic [7:0]    shreg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            active  <= 1'b0;
            clk_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            data    <= '0;
            ready   <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            ready   <= 1'b0;
            if (!active) begin
                if (!rx_s) begin
                    active  <= 1'b1;
                    clk_cnt <= '0;
                    bit_idx <= '0;
                end
            end else if (clk_cnt == ((bit_idx == 4'd0) ? CW'(HALF - 1)
                                                       : CW'(CLKS_PER_BIT - 1))) begin
                clk_cnt <= '0;
                if (bit_idx == 4'd0) begin
                    // glitch shorter than half a bit: not a start bit
                    if (rx_s) active <= 1'b0;
                    else      bit_idx <= 4'd1;
                end else if (bit_idx <= 4'd8) begin
                    shreg   <= {rx_s, shreg[7:1]};
                    bit_idx <= bit_idx + 4'd1;
                end else begin
                    active <= 1'b0;
                    if (rx_s) begin
                        data  <= shreg;
                        ready <= 1'b1;
                    end
                end
            end else begin
                clk_cnt <= clk_cnt + CW'(1);
            end
        end
    end
endmodule

// File: rtl/uart_adc_poller.sv
// uart_adc_poller
//   Polls a serial ADC front-end over UART, one channel per poll slot.
//   Each poll sends CMD_BASE+channel, then expects a two-byte reply
//   (low byte first); the low ADC_WIDTH bits of {b1,b0} become the sample.
//   No complete reply within TIMEOUT_BYTES byte-times clears the channel's
//   valid flag and bumps a saturating timeout counter.
//   Ports:
//     clk, rst_n         system clock, async active-low reset
//     rx / tx            UART lines to the ADC front-end (idle high)
//     enable             permits new polls to start
//     adc_data           channel n at [n*ADC_WIDTH +: ADC_WIDTH]
//     adc_valid          last poll of channel n succeeded
//     sample_strobe      1-cycle pulse when channel n is updated
//     timeout_count      saturating count of timed-out polls
//     busy               a poll transaction is in progress
module uart_adc_poller
    import uart_adc_poller_pkg::*;
#(
    parameter int         CLK_FREQ      = 12000000,
    parameter int         BAUD          = 250000,
    parameter int         CHANNELS      = 4,
    parameter int         ADC_WIDTH     = 10,
    parameter int         POLL_HZ       = 400,
    parameter logic [7:0] CMD_BASE      = 8'hA1,
    parameter int         TIMEOUT_BYTES = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx,
    output logic                          tx,
    input  logic                          enable,
    output logic [CHANNELS*ADC_WIDTH-1:0] adc_data,
    output logic [CHANNELS-1:0]           adc_valid,
    output logic [CHANNELS-1:0]           sample_strobe,
    output logic [15:0]                   timeout_count,
    output logic                          busy
);
    localparam int SLOT_CYC     = slot_cycles(CLK_FREQ, POLL_HZ);
    localparam int TO_CYC       = timeout_cycles(CLK_FREQ, BAUD, TIMEOUT_BYTES);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int SLOT_W       = $clog2(SLOT_CYC + 1);
    localparam int TO_W         = $clog2(TO_CYC + 1);
    localparam int CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    state_t                state, state_nxt;
    logic [SLOT_W-1:0]     slot_cnt;
    logic                  slot_wrap;
    logic                  pending;
    logic                  take;
    logic [CH_W-1:0]       channel, channel_nxt;
    logic [CHANNELS-1:0]   ch_mask;
    logic                  byte_cnt;
    logic [7:0]            low_byte;
    logic [TO_W-1:0]       to_cnt;
    logic                  expired;
    logic                  got_word;
    logic [ADC_WIDTH-1:0]  sample;
    logic                  tx_start, tx_busy;
    logic [7:0]            tx_data;
    logic [7:0]            rx_data;
    logic                  rx_ready;

    assign slot_wrap   = (slot_cnt == SLOT_W'(SLOT_CYC - 1));
    assign take        = (state == ST_IDLE) && pending && enable;
    assign tx_start    = (state == ST_SEND);
    assign tx_data     = cmd_for(CMD_BASE, 8'(channel));
    assign ch_mask     = CHANNELS'(1) << channel;
    assign channel_nxt = (channel == CH_W'(CHANNELS - 1)) ? '0 : channel + CH_W'(1);
    assign sample      = ADC_WIDTH'({rx_data, low_byte});
    assign got_word    = (state == ST_RECV) && rx_ready && byte_cnt;
    // A byte arriving on the expiry cycle wins. The counter keeps running
    // after the first byte, so >= catches an expiry that a byte pre-empted.
    assign expired     = (state == ST_RECV) && !rx_ready && (to_cnt >= TO_W'(TO_CYC - 1));
    assign busy        = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (pending && enable) state_nxt = ST_SEND;
            ST_SEND:    state_nxt = ST_WAIT_TX;
            ST_WAIT_TX: if (!tx_busy) state_nxt = ST_RECV;
            ST_RECV: begin
                if (got_word)     state_nxt = ST_COMMIT;
                else if (expired) state_nxt = ST_IDLE;
            end
            ST_COMMIT:  state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt      <= '0;
            pending       <= 1'b0;
            channel       <= '0;
            byte_cnt      <= 1'b0;
            low_byte      <= '0;
            to_cnt        <= '0;
            adc_data      <= '0;
            adc_valid     <= '0;
            sample_strobe <= '0;
            timeout_count <= '0;
        end else begin
            sample_strobe <= '0;
            slot_cnt      <= slot_wrap ? '0 : slot_cnt + SLOT_W'(1);
            // single-deep request: wraps while already pending are lost
            if (take)           pending <= 1'b0;
            else if (slot_wrap) pending <= 1'b1;

            case (state)
                ST_WAIT_TX: begin
                    byte_cnt <= 1'b0;
                    to_cnt   <= '0;
                end
                ST_RECV: begin
                    if (rx_ready) begin
                        if (!byte_cnt) begin
                            low_byte <= rx_data;
                            byte_cnt <= 1'b1;
                            to_cnt   <= to_cnt + TO_W'(1);
                        end else begin
                            // registered here so data/strobe appear in COMMIT,
                            // the cycle after the second byte's ready pulse
                            for (int n = 0; n < CHANNELS; n++)
                                if (ch_mask[n]) adc_data[n*ADC_WIDTH +: ADC_WIDTH] <= sample;
                            adc_valid     <= adc_valid | ch_mask;
                            sample_strobe <= ch_mask;
                        end
                    end else if (expired) begin
                        adc_valid <= adc_valid & ~ch_mask;
                        if (timeout_count != 16'hFFFF) timeout_count <= timeout_count + 16'd1;
                        byte_cnt  <= 1'b0;
                        channel   <= channel_nxt;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                ST_COMMIT: channel <= channel_nxt;
                default: ;
            endcase
        end
    end

    uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clk   (clk),
        .rst_n (rst_n),
        .start (tx_start),
        .data  (tx_data),
        .tx    (tx),
        .busy  (tx_busy)
    );

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (rx),
        .data  (rx_data),
        .ready (rx_ready)
    );
endmodule
